// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer wrapped around the combinational 32-bit ALU: launches
// registered operands, waits a fixed settle interval, then holds the captured result.
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [2:0]             in_op,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_sel,
  input  logic [31:0]            alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_over,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_carry,
  output logic                   out_over,
  output logic                   out_zero,
  output logic [2:0]             out_op,
  output logic [COUNT_WIDTH-1:0] op_count
);

  localparam int SettleEff = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CntW      = (SettleEff > 1) ? $clog2(SettleEff) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleEff - 1);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpSlt = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

  state_t                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [31:0]              aluA_q, aluA_d;
  logic [31:0]              aluB_q, aluB_d;
  logic [2:0]               aluSel_q, aluSel_d;
  logic [31:0]              result_q, result_d;
  logic                     carry_q, carry_d;
  logic                     over_q, over_d;
  logic                     zero_q, zero_d;
  logic [2:0]               outOp_q, outOp_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     accept;
  logic                     handshake;
  logic                     isArith;

  assign in_ready   = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept     = in_valid && in_ready;
  assign handshake  = (state_q == HOLD) && out_ready;
  assign isArith    = (aluSel_q == OpAdd) || (aluSel_q == OpSub);

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_sel    = aluSel_q;
  assign out_valid  = (state_q == HOLD);
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_over   = over_q;
  assign out_zero   = zero_q;
  assign out_op     = outOp_q;
  assign op_count   = count_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    aluA_d   = aluA_q;
    aluB_d   = aluB_q;
    aluSel_d = aluSel_q;
    result_d = result_q;
    carry_d  = carry_q;
    over_d   = over_q;
    zero_d   = zero_q;
    outOp_d  = outOp_q;
    count_d  = count_q;

    case (state_q)
      IDLE: ;
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Flags that are meaningless for the selected command are masked here
          result_d = alu_result;
          outOp_d  = aluSel_q;
          zero_d   = (alu_result == 32'd0);
          carry_d  = isArith ? alu_carry : 1'b0;
          over_d   = (isArith || (aluSel_q == OpSlt)) ? alu_over : 1'b0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = IDLE;
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A launch overrides the HOLD->IDLE return so handshake and accept share one edge
    if (accept) begin
      aluA_d   = in_a;
      aluB_d   = in_b;
      aluSel_d = in_op;
      cnt_d    = CntLoad;
      state_d  = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      aluA_q   <= '0;
      aluB_q   <= '0;
      aluSel_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      over_q   <= 1'b0;
      zero_q   <= 1'b1;
      outOp_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      aluA_q   <= aluA_d;
      aluB_q   <= aluB_d;
      aluSel_q <= aluSel_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      over_q   <= over_d;
      zero_q   <= zero_d;
      outOp_q  <= outOp_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Clocked issue/capture sequencer that sits directly in front of and behind the 32-bit combinational ALU. It accepts one operation per valid/ready handshake and drives registered a/b/selector into the ALU. It waits a fixed settle interval that covers the ALU's worst-case gate delay, then captures result and flags. It presents the captured values downstream on a valid/ready output handshake.

Parameters:
SETTLE_CYCLES, 4, clock edges from operand launch to result capture; values <1 treated as 1
COUNT_WIDTH, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream operation valid
in_ready  output  1  block can accept operation this cycle
in_a  input  32  operand a
in_b  input  32  operand b
in_op  input  3  command: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR
alu_a  output  32  registered operand a to ALU
alu_b  output  32  registered operand b to ALU
alu_sel  output  3  registered selector to ALU
alu_result  input  32  ALU result
alu_carry  input  1  ALU carry flag
alu_over  input  1  ALU overflow flag
out_valid  output  1  captured result valid
out_ready  input  1  downstream accepts result
out_result  output  32  captured result
out_carry  output  1  captured carry (masked)
out_over  output  1  captured overflow (masked)
out_zero  output  1  1 when out_result == 0
out_op  output  3  command that produced out_result
op_count  output  COUNT_WIDTH  completed output handshakes, saturating

Behaviour:
- Reset (synchronous, reset=1 at rising edge): state IDLE; alu_a/alu_b/alu_sel/out_result/out_op = 0; out_valid/out_carry/out_over = 0; out_zero = 1 (consistent with out_result=0); op_count = 0; settle counter = 0.
- Reset has priority over all other events. An in-flight op (SETTLE or HOLD) is discarded, and out_valid never asserts for it.
- States: IDLE, SETTLE, HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational from state and out_ready, and never depends on in_valid.
- Accept = in_valid && in_ready at a rising edge. On accept: alu_a<=in_a, alu_b<=in_b, alu_sel<=in_op, counter<=SETTLE_CYCLES-1, state<=SETTLE.
- SETTLE: alu_* held stable. If counter != 0, decrement. If counter == 0, capture and go to HOLD, setting:
  - out_result<=alu_result
  - out_op<=alu_sel
  - out_zero<=(alu_result==0)
  - out_carry<=alu_carry only for ADD/SUB, else 0
  - out_over<=alu_over for ADD/SUB/SLT, else 0
- Latency: op accepted at edge k is captured at edge k+SETTLE_CYCLES; out_valid is high from that edge.
- HOLD: out_valid=1, and out_* stay stable until handshake (out_valid && out_ready).
  - On handshake without accept: state<=IDLE, out_valid<=0.
  - On handshake with accept in the same edge: the new op is launched, state<=SETTLE, out_valid<=0. This gives back-to-back throughput of one op per SETTLE_CYCLES+1 edges.
- out_* data registers retain their last value after handshake; only out_valid drops.
- op_count increments by 1 on each output handshake and saturates at all-ones; no wrap.
- in_valid in SETTLE is ignored (in_ready=0). Upstream must hold in_a/in_b/in_op stable while in_valid && !in_ready.
- out_ready while out_valid=0 has no effect.
- No path from in_* to out_* is combinational. alu_* change only on accept or reset.

Test Plan:
- SETTLE_CYCLES=4, ADD 5+7 accepted at edge 0, out_ready=1 -> out_valid rises after edge 4; out_result=12, carry=0, over=0, zero=0, out_op=0; op_count=1 after edge 5.
- SUB a=0x80000000 b=1 -> out_result=0x7FFFFFFF, out_over=1, out_carry=1. SUB 9-9 -> out_result=0, out_zero=1, out_carry=1.
- ALU model forces alu_carry=alu_over=1 for XOR 0xF0F0F0F0^0xFFFFFFFF -> out_result=0x0F0F0F0F, out_carry=0, out_over=0. SLT with alu_over=1 -> out_over=1, out_carry=0.
- Backpressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 -> out_* stable, in_ready=0. Then out_ready=1 -> handshake and new accept on the same edge; next out_valid exactly SETTLE_CYCLES edges later.
- reset=1 for one edge during SETTLE (counter=2) -> all outputs at reset values next cycle; out_valid never asserts for the aborted op; op_count=0.
- COUNT_WIDTH=4, 20 consecutive ops drained -> op_count reaches 15 and stays 15.
